// File: rtl/sdm_div_cfg_ctrl.sv
// Ramp/settle sequencer driving N/frac of the sigma-delta fractional-N divider loop.
// Optional request bound checking is enabled by defining SDM_CFG_BOUND_CHK_EN.
module sdm_div_cfg_ctrl #(
    parameter int NW         = 6,
    parameter int FW         = 10,
    parameter int RST_N      = 31,
    parameter int RST_FRAC   = 416,
    parameter int SETTLE_CYC = 64,
    parameter int N_MIN      = 16,
    parameter int N_MAX      = 60
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req,
    input  logic [NW-1:0]    n_req,
    input  logic [FW-1:0]    frac_req,
    input  logic [NW+FW-1:0] step,
    input  logic             abort,
    input  logic             div_edge,
    output logic [NW-1:0]    N,
    output logic [FW-1:0]    frac,
    output logic             busy,
    output logic             ack,
    output logic             err
);

    localparam int WW = NW + FW;
    localparam int CW = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
    localparam logic [WW-1:0] RST_W = {NW'(RST_N), FW'(RST_FRAC)};

    typedef enum logic [1:0] {IDLE, RAMP, SETTLE, DONE} state_t;

    state_t        state, state_nxt;
    logic [WW-1:0] cur_w, cur_nxt;
    logic [WW-1:0] tgt_w, tgt_nxt;
    logic [WW-1:0] step_r, step_nxt;
    logic [WW-1:0] diff;
    logic [CW-1:0] cnt, cnt_nxt;

`ifdef SDM_CFG_BOUND_CHK_EN
    logic n_legal;
    logic err_r, err_nxt;

    assign n_legal = (int'(n_req) >= N_MIN) && (int'(n_req) <= N_MAX);
    assign err     = err_r;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) err_r <= 1'b0;
        else       err_r <= err_nxt;
    end
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cur_nxt   = cur_w;
        tgt_nxt   = tgt_w;
        step_nxt  = step_r;
        cnt_nxt   = cnt;
`ifdef SDM_CFG_BOUND_CHK_EN
        err_nxt   = 1'b0;
`endif
        diff = (tgt_w >= cur_w) ? (tgt_w - cur_w) : (cur_w - tgt_w);

        case (state)
            IDLE: begin
                if (req && !abort) begin
`ifdef SDM_CFG_BOUND_CHK_EN
                    if (!n_legal) err_nxt = 1'b1;
                    else
`endif
                    begin
                        tgt_nxt   = {n_req, frac_req};
                        step_nxt  = step;
                        state_nxt = RAMP;
                    end
                end
            end
            RAMP: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (div_edge) begin
                    // Combined {N,frac} arithmetic handles frac carry/borrow into N.
                    if (step_r == '0 || diff <= step_r) begin
                        cur_nxt   = tgt_w;
                        state_nxt = (SETTLE_CYC == 0) ? DONE : SETTLE;
                    end else if (tgt_w > cur_w) begin
                        cur_nxt = cur_w + step_r;
                    end else begin
                        cur_nxt = cur_w - step_r;
                    end
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (div_edge) begin
                    if (cnt == CW'(SETTLE_CYC - 1)) begin
                        cnt_nxt   = '0;
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            cur_w  <= RST_W;
            tgt_w  <= RST_W;
            step_r <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            cur_w  <= cur_nxt;
            tgt_w  <= tgt_nxt;
            step_r <= step_nxt;
            cnt    <= cnt_nxt;
        end
    end

    assign N    = cur_w[WW-1:FW];
    assign frac = cur_w[FW-1:0];
    assign busy = (state == RAMP) || (state == SETTLE);
    assign ack  = (state == DONE);

endmodule

// File: tb/tb_sdm_div_cfg_ctrl.sv
// Scoreboard bench for sdm_div_cfg_ctrl: expected N/frac words are queued per request
// and popped as each div_edge takes effect.
module tb_sdm_div_cfg_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req = 1'b0;
    logic [5:0]  n_req = '0;
    logic [9:0]  frac_req = '0;
    logic [15:0] step = '0;
    logic        abort = 1'b0;
    logic        div_edge = 1'b0;
    logic [5:0]  N;
    logic [9:0]  frac;
    logic        busy, ack, err;

    int total = 0;
    int bad = 0;
    int ack_cnt = 0;
    logic [15:0] exp_q[$];

    sdm_div_cfg_ctrl #(
        .NW(6), .FW(10), .RST_N(31), .RST_FRAC(416),
        .SETTLE_CYC(64), .N_MIN(16), .N_MAX(60)
    ) dut (
        .clk(clk), .rstn(rstn), .req(req), .n_req(n_req), .frac_req(frac_req),
        .step(step), .abort(abort), .div_edge(div_edge),
        .N(N), .frac(frac), .busy(busy), .ack(ack), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ack) ack_cnt++;

    function automatic logic [15:0] w(input int n, input int f);
        return {6'(n), 10'(f)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (3) cyc();
        rstn = 1'b1;
        cyc();
    endtask

    task automatic send_req(input int n, input int f, input int s);
        n_req = 6'(n); frac_req = 10'(f); step = 16'(s);
        req = 1'b1;
        cyc();
        req = 1'b0;
    endtask

    task automatic do_edge();
        div_edge = 1'b1;
        cyc();
        div_edge = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (10) cyc();
        total++;
        if ({N, frac} !== w(31, 416) || busy !== 1'b0 || ack !== 1'b0) begin
            bad++;
            $display("FAIL reset_in: N=%0d frac=%0d busy=%b ack=%b want 31/416 0 0", N, frac, busy, ack);
        end
        rstn = 1'b1;
        repeat (5) cyc();
        total++;
        if ({N, frac} !== w(31, 416) || busy !== 1'b0 || ack !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: N=%0d frac=%0d busy=%b ack=%b want 31/416 0 0", N, frac, busy, ack);
        end
    endtask

    task automatic test_direct_jump();
        logic [15:0] e;
        int a0;
        send_req(31, 516, 0);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL jump_busy: busy=%b want 1", busy); end
        exp_q.push_back(w(31, 516));
        while (exp_q.size() > 0) begin
            do_edge();
            e = exp_q.pop_front();
            total++;
            if ({N, frac} !== e) begin
                bad++;
                $display("FAIL jump_word: got %0d/%0d want %0d/%0d", N, frac, e[15:10], e[9:0]);
            end
        end
        a0 = ack_cnt;
        repeat (63) do_edge();
        total++;
        if (busy !== 1'b1 || ack_cnt !== a0) begin
            bad++;
            $display("FAIL jump_settle63: busy=%b acks=%0d want 1 0", busy, ack_cnt - a0);
        end
        do_edge();
        total++;
        if (busy !== 1'b0 || ack_cnt !== a0 + 1) begin
            bad++;
            $display("FAIL jump_ack: busy=%b acks=%0d want 0 1", busy, ack_cnt - a0);
        end
    endtask

    task automatic test_up_ramp();
        logic [15:0] e;
        int a0;
        do_reset();
        send_req(32, 0, 200);
        exp_q.push_back(w(31, 616));
        exp_q.push_back(w(31, 816));
        exp_q.push_back(w(31, 1016));
        exp_q.push_back(w(32, 0));
        while (exp_q.size() > 0) begin
            do_edge();
            e = exp_q.pop_front();
            total++;
            if ({N, frac} !== e) begin
                bad++;
                $display("FAIL up_word: got %0d/%0d want %0d/%0d", N, frac, e[15:10], e[9:0]);
            end
        end
        a0 = ack_cnt;
        repeat (64) do_edge();
        total++;
        if (busy !== 1'b0 || ack_cnt !== a0 + 1 || {N, frac} !== w(32, 0)) begin
            bad++;
            $display("FAIL up_ack: busy=%b acks=%0d N=%0d frac=%0d want 0 1 32/0", busy, ack_cnt - a0, N, frac);
        end
    endtask

    task automatic test_down_ramp();
        logic [15:0] e;
        int a0;
        send_req(31, 900, 100);
        exp_q.push_back(w(31, 924));
        exp_q.push_back(w(31, 900));
        while (exp_q.size() > 0) begin
            do_edge();
            e = exp_q.pop_front();
            total++;
            if ({N, frac} !== e) begin
                bad++;
                $display("FAIL down_word: got %0d/%0d want %0d/%0d", N, frac, e[15:10], e[9:0]);
            end
        end
        a0 = ack_cnt;
        repeat (64) do_edge();
        total++;
        if (busy !== 1'b0 || ack_cnt !== a0 + 1) begin
            bad++;
            $display("FAIL down_ack: busy=%b acks=%0d want 0 1", busy, ack_cnt - a0);
        end
    endtask

    task automatic test_abort();
        logic [15:0] e;
        int a0;
        do_reset();
        a0 = ack_cnt;
        send_req(32, 0, 200);
        exp_q.push_back(w(31, 616));
        exp_q.push_back(w(31, 816));
        while (exp_q.size() > 0) begin
            do_edge();
            e = exp_q.pop_front();
            total++;
            if ({N, frac} !== e) begin
                bad++;
                $display("FAIL abort_word: got %0d/%0d want %0d/%0d", N, frac, e[15:10], e[9:0]);
            end
        end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: busy=%b want 0", busy); end
        repeat (70) do_edge();
        total++;
        if ({N, frac} !== w(31, 816) || ack_cnt !== a0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_freeze: N=%0d frac=%0d acks=%0d busy=%b want 31/816 0 0", N, frac, ack_cnt - a0, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        int a0;
        a0 = ack_cnt;
        send_req(31, 1016, 100);
        exp_q.push_back(w(31, 916));
        exp_q.push_back(w(31, 1016));
        do_edge();
        send_req(40, 0, 0);
        while (exp_q.size() > 0) begin
            if (exp_q.size() == 1) do_edge();
            e = exp_q.pop_front();
            total++;
            if ({N, frac} !== e) begin
                bad++;
                $display("FAIL overlap_word: got %0d/%0d want %0d/%0d", N, frac, e[15:10], e[9:0]);
            end
        end
        repeat (70) do_edge();
        total++;
        if ({N, frac} !== w(31, 1016) || ack_cnt !== a0 + 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL overlap_end: N=%0d frac=%0d acks=%0d busy=%b want 31/1016 1 0", N, frac, ack_cnt - a0, busy);
        end
    endtask

    task automatic test_same_target_and_req_abort();
        int a0;
        a0 = ack_cnt;
        n_req = 6'd20; frac_req = 10'd5; step = '0;
        req = 1'b1; abort = 1'b1;
        cyc();
        req = 1'b0; abort = 1'b0;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL req_abort: busy=%b want 0", busy); end
        send_req(31, 1016, 7);
        do_edge();
        total++;
        if ({N, frac} !== w(31, 1016) || busy !== 1'b1) begin
            bad++;
            $display("FAIL same_tgt: N=%0d frac=%0d busy=%b want 31/1016 1", N, frac, busy);
        end
        repeat (64) do_edge();
        total++;
        if (ack_cnt !== a0 + 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL same_ack: acks=%0d busy=%b want 1 0", ack_cnt - a0, busy);
        end
    endtask

    task automatic test_async_reset();
        send_req(40, 0, 300);
        do_edge();
        #2 rstn = 1'b0;
        #1;
        total++;
        if ({N, frac} !== w(31, 416) || busy !== 1'b0) begin
            bad++;
            $display("FAIL async_rst: N=%0d frac=%0d busy=%b want 31/416 0", N, frac, busy);
        end
        cyc();
        rstn = 1'b1;
        cyc();
    endtask

`ifdef SDM_CFG_BOUND_CHK_EN
    task automatic test_bound();
        int a0;
        a0 = ack_cnt;
        send_req(10, 0, 0);
        total++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL bound_err: err=%b busy=%b want 1 0", err, busy);
        end
        cyc();
        total++;
        if (err !== 1'b0 || {N, frac} !== w(31, 416)) begin
            bad++;
            $display("FAIL bound_hold: err=%b N=%0d frac=%0d want 0 31/416", err, N, frac);
        end
        send_req(60, 0, 0);
        total++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL bound_legal: err=%b busy=%b want 0 1", err, busy);
        end
        repeat (65) do_edge();
        total++;
        if ({N, frac} !== w(60, 0) || ack_cnt !== a0 + 1) begin
            bad++;
            $display("FAIL bound_ack: N=%0d frac=%0d acks=%0d want 60/0 1", N, frac, ack_cnt - a0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_direct_jump();
        test_up_ramp();
        test_down_ramp();
        test_abort();
        test_back_to_back();
        test_same_target_and_req_abort();
        test_async_reset();
`ifdef SDM_CFG_BOUND_CHK_EN
        test_bound();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
